// File: rtl/ram_fifo_ctrl_if.sv
// Stream-in, stream-out and RAM-side signals of the RAM-backed FWFT FIFO controller.
// The slave modport is the controller's view; master is the environment (producer, consumer, RAM).
interface ram_fifo_ctrl_if #(
  parameter int DATA_WIDTH = 24,
  parameter int ADDR_WIDTH = 9
) ();
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [ADDR_WIDTH-1:0] ram_waddr;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_raddr;
  logic                  ram_re;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic [ADDR_WIDTH+1:0] level;

  modport slave (
    input  s_data, s_valid, m_ready, ram_rdata,
    output s_ready, m_data, m_valid, ram_wdata, ram_waddr, ram_we, ram_raddr, ram_re, level
  );

  modport master (
    output s_data, s_valid, m_ready, ram_rdata,
    input  s_ready, m_data, m_valid, ram_wdata, ram_waddr, ram_we, ram_raddr, ram_re, level
  );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// Turns a simple dual-port RAM into a FWFT stream FIFO; write-to-m_valid latency 2+RD_LATENCY cycles.
// s_ready drops only when the RAM is full (after the output buffer has filled); reads are credit-limited.
module ram_fifo_ctrl #(
  parameter int DATA_WIDTH = 24,
  parameter int ADDR_WIDTH = 9,
  parameter int RD_LATENCY = 1
) (
  input  logic           clk,
  input  logic           rst,
  ram_fifo_ctrl_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int OB    = RD_LATENCY + 2;
  localparam int CW    = $clog2(OB + 1) + 1;
  localparam int PW    = ADDR_WIDTH + 1;
  localparam int LW    = ADDR_WIDTH + 2;

  logic [PW-1:0]                  wptr_q, wptr_d, wvis_q, rptr_q, rptr_d;
  logic [PW-1:0]                  cnt_vis, cnt_next;
  logic                           s_ready_q, s_ready_d;
  logic [RD_LATENCY-1:0]          tag_q, tag_d;
  logic [RD_LATENCY:0]            tag_sh;
  logic [CW-1:0]                  ob_cnt_q, ob_cnt_d, inflight, wr_idx;
  logic [OB-1:0][DATA_WIDTH-1:0]  ob_q, ob_d;
  logic [LW-1:0]                  level_q, level_d;
  logic                           wr_en, rd_en, push, pop;

  always_comb begin
    wr_en    = bus.s_valid & s_ready_q;
    pop      = (ob_cnt_q != '0) & bus.m_ready;

    // Reads only see words written at least one edge ago (wvis_q lags wptr_q),
    // so a read never targets the address being written in the same cycle.
    cnt_vis  = wvis_q - rptr_q;
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + CW'(tag_q[i]);
    end
    rd_en    = (cnt_vis != '0) && ((ob_cnt_q + inflight) < CW'(OB));

    tag_sh   = {tag_q, rd_en};
    tag_d    = tag_sh[RD_LATENCY-1:0];
    push     = tag_sh[RD_LATENCY];

    wptr_d    = wptr_q + PW'(wr_en);
    rptr_d    = rptr_q + PW'(rd_en);
    cnt_next  = wptr_d - rptr_d;
    s_ready_d = (cnt_next != PW'(DEPTH));

    ob_d   = ob_q;
    wr_idx = pop ? (ob_cnt_q - CW'(1)) : ob_cnt_q;
    if (pop) begin
      for (int i = 0; i < OB - 1; i++) begin
        ob_d[i] = ob_q[i+1];
      end
    end
    if (push) begin
      for (int i = 0; i < OB; i++) begin
        if (CW'(i) == wr_idx) begin
          ob_d[i] = bus.ram_rdata;
        end
      end
    end
    ob_cnt_d = ob_cnt_q + CW'(push) - CW'(pop);
    level_d  = level_q + LW'(wr_en) - LW'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q    <= '0;
      wvis_q    <= '0;
      rptr_q    <= '0;
      s_ready_q <= 1'b0;
      tag_q     <= '0;
      ob_cnt_q  <= '0;
      ob_q      <= '0;
      level_q   <= '0;
    end else begin
      wptr_q    <= wptr_d;
      wvis_q    <= wptr_q;
      rptr_q    <= rptr_d;
      s_ready_q <= s_ready_d;
      tag_q     <= tag_d;
      ob_cnt_q  <= ob_cnt_d;
      ob_q      <= ob_d;
      level_q   <= level_d;
    end
  end

  assign bus.s_ready   = s_ready_q;
  assign bus.m_valid   = (ob_cnt_q != '0);
  assign bus.m_data    = ob_q[0];
  assign bus.ram_wdata = bus.s_data;
  assign bus.ram_waddr = wptr_q[ADDR_WIDTH-1:0];
  assign bus.ram_we    = wr_en;
  assign bus.ram_raddr = rptr_q[ADDR_WIDTH-1:0];
  assign bus.ram_re    = rd_en;
  assign bus.level     = level_q;
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Drives two controllers (RD_LATENCY 1 and 2, 16-deep RAM) with shared stimulus;
// each copy has its own RAM model and a queue-based FIFO reference.
module tb_ram_fifo_ctrl;
  localparam int DW    = 24;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int LW    = AW + 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          s_valid = 1'b0;
  logic          m_ready = 1'b0;
  logic [DW-1:0] din = '0;

  int checks = 0;
  int errors = 0;
  int lat0, lat1, base0, base1, pb0, pb1, e0, cyc;
  logic [DW-1:0] wa, wb;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int RDL = g + 1;
    localparam int OB  = RDL + 2;
    localparam int CAP = DEPTH + OB;

    ram_fifo_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] r1, r2;
    logic [DW-1:0] q [$];
    int acc = 0;
    int popped = 0;

    assign bus.s_data    = din;
    assign bus.s_valid   = s_valid;
    assign bus.m_ready   = m_ready;
    assign bus.ram_rdata = (RDL == 1) ? r1 : r2;

    always @(posedge clk) begin
      if (bus.ram_we) mem[bus.ram_waddr] <= bus.ram_wdata;
      if (bus.ram_re) r1 <= mem[bus.ram_raddr];
      r2 <= r1;
    end

    ram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(RDL)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );

    always @(negedge clk) begin
      if (rst) begin
        q.delete();
      end else begin
        checks++;
        assert (bus.level === LW'(q.size())) else begin
          errors++; $error("FAIL level[%0d] got %0d exp %0d", g, bus.level, q.size());
        end
        if (bus.ram_we) begin
          checks++;
          assert (bus.s_ready === 1'b1) else begin
            errors++; $error("FAIL we_wo_ready[%0d] got s_ready=%0b exp 1", g, bus.s_ready);
          end
        end
        if (q.size() >= CAP) begin
          checks++;
          assert (bus.s_ready === 1'b0) else begin
            errors++; $error("FAIL ready_at_cap[%0d] got %0b exp 0 (held %0d)", g, bus.s_ready, q.size());
          end
        end
        if (bus.m_valid === 1'b1 && m_ready) begin
          checks++;
          if (q.size() == 0) begin
            errors++; $error("FAIL pop_empty[%0d] got 0x%0h exp no word", g, bus.m_data);
          end else begin
            assert (bus.m_data === q[0]) else begin
              errors++; $error("FAIL order[%0d] got 0x%0h exp 0x%0h", g, bus.m_data, q[0]);
            end
            void'(q.pop_front());
            popped++;
          end
        end
        if (s_valid && bus.s_ready === 1'b1) begin
          q.push_back(din);
          acc++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++; $error("FAIL %s got 0x%0h exp 0x%0h", tag, got, exp);
    end
  endtask

  initial begin
    // reset state, with s_valid high to show ram_we stays low
    #1 rst = 1'b1;
    s_valid = 1'b1;
    repeat (3) step();
    chk("rst_s_ready0", 32'(g_inst[0].bus.s_ready), 0);
    chk("rst_s_ready1", 32'(g_inst[1].bus.s_ready), 0);
    chk("rst_m_valid0", 32'(g_inst[0].bus.m_valid), 0);
    chk("rst_m_valid1", 32'(g_inst[1].bus.m_valid), 0);
    chk("rst_level0",   32'(g_inst[0].bus.level), 0);
    chk("rst_level1",   32'(g_inst[1].bus.level), 0);
    chk("rst_we0",      32'(g_inst[0].bus.ram_we), 0);
    chk("rst_re0",      32'(g_inst[0].bus.ram_re), 0);
    s_valid = 1'b0;
    step();
    rst = 1'b0;
    #1 chk("pre_edge_ready0", 32'(g_inst[0].bus.s_ready), 0);
    step();
    chk("post_edge_ready0", 32'(g_inst[0].bus.s_ready), 1);
    chk("post_edge_ready1", 32'(g_inst[1].bus.s_ready), 1);

    // single word: latency and level
    din = 24'hABCDEF; s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    lat0 = 0; lat1 = 0;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (lat0 == 0 && g_inst[0].bus.m_valid) begin
        lat0 = k; chk("single_data0", 32'(g_inst[0].bus.m_data), 32'hABCDEF);
      end
      if (lat1 == 0 && g_inst[1].bus.m_valid) begin
        lat1 = k; chk("single_data1", 32'(g_inst[1].bus.m_data), 32'hABCDEF);
      end
    end
    chk("latency_rdl1", 32'(lat0), 3);
    chk("latency_rdl2", 32'(lat1), 4);
    chk("single_level0", 32'(g_inst[0].bus.level), 1);
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    chk("single_pop_level0", 32'(g_inst[0].bus.level), 0);
    chk("single_pop_level1", 32'(g_inst[1].bus.level), 0);

    // fill with m_ready low, incrementing pattern
    base0 = g_inst[0].acc; base1 = g_inst[1].acc;
    din = '0; s_valid = 1'b1;
    cyc = 0;
    while ((g_inst[0].bus.s_ready || g_inst[1].bus.s_ready) && cyc < 60) begin
      step(); din = din + 1'b1; cyc++;
    end
    s_valid = 1'b0;
    step();
    chk("fill_bounded", 32'(cyc < 60), 1);
    chk("fill_count0", 32'(g_inst[0].acc - base0), DEPTH + 3);
    chk("fill_count1", 32'(g_inst[1].acc - base1), DEPTH + 4);
    chk("fill_level0", 32'(g_inst[0].bus.level), DEPTH + 3);
    chk("fill_level1", 32'(g_inst[1].bus.level), DEPTH + 4);
    chk("fill_head1",  32'(g_inst[1].bus.m_data), 0);
    m_ready = 1'b1;
    e0 = 0;
    for (int k = 0; k < 40; k++) begin
      if (g_inst[0].bus.m_valid) begin
        chk("drain_pattern0", 32'(g_inst[0].bus.m_data), 32'(e0));
        e0++;
      end
      step();
    end
    chk("drain_words0", 32'(e0), DEPTH + 3);
    chk("drain_level1", 32'(g_inst[1].bus.level), 0);

    // continuous streaming: no gaps once primed
    base0 = g_inst[0].acc;
    s_valid = 1'b1; m_ready = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      din = DW'($urandom);
      step();
      if (k >= 10) begin
        chk("stream_valid0", 32'(g_inst[0].bus.m_valid), 1);
        chk("stream_valid1", 32'(g_inst[1].bus.m_valid), 1);
      end
    end
    s_valid = 1'b0;
    repeat (20) step();
    chk("stream_wraps", 32'((g_inst[0].acc - base0) >= 30 * DEPTH), 1);
    chk("stream_level0", 32'(g_inst[0].bus.level), 0);

    // random valid/ready
    base0 = g_inst[0].acc; base1 = g_inst[1].acc;
    pb0 = g_inst[0].popped; pb1 = g_inst[1].popped;
    cyc = 0;
    while ((g_inst[0].acc - base0) < 10000 && cyc < 60000) begin
      s_valid = 1'($urandom_range(0, 1));
      m_ready = 1'($urandom_range(0, 1));
      din     = DW'($urandom);
      step(); cyc++;
    end
    chk("rand_done", 32'((g_inst[0].acc - base0) >= 10000), 1);
    s_valid = 1'b0; m_ready = 1'b1;
    repeat (30) step();
    chk("rand_level0", 32'(g_inst[0].bus.level), 0);
    chk("rand_level1", 32'(g_inst[1].bus.level), 0);
    chk("rand_conserve0", 32'(g_inst[0].popped - pb0), 32'(g_inst[0].acc - base0));
    chk("rand_conserve1", 32'(g_inst[1].popped - pb1), 32'(g_inst[1].acc - base1));

    // reset with stored words and reads in flight
    m_ready = 1'b0; s_valid = 1'b1;
    for (int k = 0; k < 25; k++) begin
      din = DW'($urandom); step();
    end
    s_valid = 1'b0;
    m_ready = 1'b1; step();
    m_ready = 1'b0; step();
    rst = 1'b1;
    #1;
    chk("midrst_valid0", 32'(g_inst[0].bus.m_valid), 0);
    chk("midrst_valid1", 32'(g_inst[1].bus.m_valid), 0);
    chk("midrst_level0", 32'(g_inst[0].bus.level), 0);
    chk("midrst_level1", 32'(g_inst[1].bus.level), 0);
    step();
    rst = 1'b0;
    step();
    chk("midrst_ready0", 32'(g_inst[0].bus.s_ready), 1);
    chk("midrst_ready1", 32'(g_inst[1].bus.s_ready), 1);
    din = 24'h123456; s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    for (int k = 0; k < 10 && !(g_inst[0].bus.m_valid && g_inst[1].bus.m_valid); k++) step();
    chk("postrst_first0", 32'(g_inst[0].bus.m_data), 32'h123456);
    chk("postrst_first1", 32'(g_inst[1].bus.m_data), 32'h123456);
    m_ready = 1'b1; step();
    m_ready = 1'b0; step();

    // pop on first valid cycle while a second word is written
    wa = DW'($urandom); wb = DW'($urandom);
    din = wa; s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    for (int k = 0; k < 10 && !g_inst[0].bus.m_valid; k++) step();
    chk("coll_first_valid", 32'(g_inst[0].bus.m_valid), 1);
    chk("coll_first_data",  32'(g_inst[0].bus.m_data), 32'(wa));
    m_ready = 1'b1; s_valid = 1'b1; din = wb;
    step();
    m_ready = 1'b0; s_valid = 1'b0;
    for (int k = 0; k < 10 && !g_inst[0].bus.m_valid; k++) step();
    chk("coll_second_valid", 32'(g_inst[0].bus.m_valid), 1);
    chk("coll_second_data",  32'(g_inst[0].bus.m_data), 32'(wb));
    m_ready = 1'b1;
    repeat (20) step();
    chk("final_level0", 32'(g_inst[0].bus.level), 0);
    chk("final_level1", 32'(g_inst[1].bus.level), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
